// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU control codes, ALU operation classes, mux selects and FSM state codes.
package multicycle_controller_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class requested by the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUFLOP = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;

  // FSM state encodings; 4'd15 is unused and recovers to FETCH1
  localparam logic [3:0] S_FETCH1  = 4'd0;
  localparam logic [3:0] S_FETCH2  = 4'd1;
  localparam logic [3:0] S_FETCH3  = 4'd2;
  localparam logic [3:0] S_FETCH4  = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_MEMADR  = 4'd5;
  localparam logic [3:0] S_LBRD    = 4'd6;
  localparam logic [3:0] S_LBWR    = 4'd7;
  localparam logic [3:0] S_SBWR    = 4'd8;
  localparam logic [3:0] S_RTYPEEX = 4'd9;
  localparam logic [3:0] S_RTYPEWR = 4'd10;
  localparam logic [3:0] S_BEQEX   = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;
  localparam logic [3:0] S_ADDIEX  = 4'd13;
  localparam logic [3:0] S_ADDIWR  = 4'd14;

  // Byte lane of the instruction register loaded in a given fetch state
  function automatic logic [3:0] fetch_lane(input logic [3:0] st);
    logic [3:0] lane;
    lane = 4'b0000;
    case (st)
      S_FETCH1: lane = 4'b0001;
      S_FETCH2: lane = 4'b0010;
      S_FETCH3: lane = 4'b0100;
      S_FETCH4: lane = 4'b1000;
      default:  lane = 4'b0000;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decoder: maps the FSM's ALU operation class and the
// instruction funct field to an ALU control code, and flags unsupported functs.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       funct_ok
);

  logic [2:0] funct_alu;

  // Decode the funct field independently of aluop so DECODE can test legality
  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      FUNCT_ADD: funct_alu = ALU_ADD;
      FUNCT_SUB: funct_alu = ALU_SUB;
      FUNCT_AND: funct_alu = ALU_AND;
      FUNCT_OR:  funct_alu = ALU_OR;
      FUNCT_SLT: funct_alu = ALU_SLT;
      default: begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b0;
      end
    endcase
  end

  // Select the final ALU control from the requested operation class
  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   alucont = ALU_ADD;
      ALUOP_SUB:   alucont = ALU_SUB;
      ALUOP_FUNCT: alucont = funct_alu;
      default:     alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the 8-bit multicycle MIPS datapath. All selects and
// strobes decode from the registered state; pcen additionally uses zero.
// Write strobes and illegal are held low while reset is asserted (low).
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource,
  output logic       illegal
);

  logic [3:0] state;
  logic [3:0] state_next;
  logic [1:0] aluop;
  logic       alu_used;
  logic [2:0] dec_alucont;
  logic       funct_ok;
  logic       pcwrite;
  logic       branch;
  logic       memwrite_raw;
  logic       regwrite_raw;
  logic [3:0] irwrite_raw;
  logic       illegal_raw;

  alu_decoder u_alu_decoder (
    .aluop    (aluop),
    .funct    (funct),
    .alucont  (dec_alucont),
    .funct_ok (funct_ok)
  );

  // State register; reset restarts at FETCH1 even mid-instruction
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH1;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DECODE dispatches on op and flags unsupported instructions
  always_comb begin
    state_next  = S_FETCH1;
    illegal_raw = 1'b0;
    case (state)
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: state_next = S_FETCH3;
      S_FETCH3: state_next = S_FETCH4;
      S_FETCH4: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_next = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_next = S_RTYPEEX;
            end else begin
              state_next  = S_FETCH1;
              illegal_raw = 1'b1;
            end
          end
          OP_BEQ:  state_next = S_BEQEX;
          OP_J:    state_next = S_JEX;
          OP_ADDI: state_next = S_ADDIEX;
          default: begin
            state_next  = S_FETCH1;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_next = (op == OP_SB) ? S_SBWR : S_LBRD;
      S_LBRD:    state_next = S_LBWR;
      S_LBWR:    state_next = S_FETCH1;
      S_SBWR:    state_next = S_FETCH1;
      S_RTYPEEX: state_next = S_RTYPEWR;
      S_RTYPEWR: state_next = S_FETCH1;
      S_BEQEX:   state_next = S_FETCH1;
      S_JEX:     state_next = S_FETCH1;
      S_ADDIEX:  state_next = S_ADDIWR;
      S_ADDIWR:  state_next = S_FETCH1;
      default:   state_next = S_FETCH1;
    endcase
  end

  // Per-state output decode; anything not set for a state stays 0
  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 4'b0000;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REGB;
    aluop        = ALUOP_ADD;
    alu_used     = 1'b0;
    pcsource     = PCSRC_ALU;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        irwrite_raw = fetch_lane(state);
        alusrcb     = SRCB_ONE;
        alu_used    = 1'b1;
        pcwrite     = 1'b1;
      end
      S_DECODE: begin
        alusrcb  = SRCB_IMMSH;
        alu_used = 1'b1;
      end
      S_MEMADR: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_IMM;
        alu_used = 1'b1;
      end
      S_LBRD: iord = 1'b1;
      S_LBWR: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_SBWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_FUNCT;
        alu_used = 1'b1;
      end
      S_RTYPEWR: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        alu_used = 1'b1;
        branch   = 1'b1;
        pcsource = PCSRC_ALUFLOP;
      end
      S_JEX: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_IMM;
        alu_used = 1'b1;
      end
      S_ADDIWR: regwrite_raw = 1'b1;
      default: begin
        iord = 1'b0;
      end
    endcase
  end

  // ALU control is only driven in states that use the ALU
  assign alucont  = alu_used ? dec_alucont : 3'b000;

  // Strobes are suppressed while reset is held low
  assign pcen     = reset & (pcwrite | (branch & zero));
  assign memwrite = reset & memwrite_raw;
  assign regwrite = reset & regwrite_raw;
  assign irwrite  = irwrite_raw & {4{reset}};
  assign illegal  = reset & illegal_raw;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: expected per-cycle output
// vectors are queued as each instruction is set up and compared cycle by cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [3:0] irwrite;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucont;

  typedef logic [18:0] vec_t;
  vec_t obs;
  vec_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  multicycle_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .pcen     (pcen),
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .alucont  (alucont),
    .pcsource (pcsource),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, alucont, pcsource, illegal};

  function automatic vec_t mk(input logic pe, input logic io, input logic mw,
                              input logic [3:0] irw, input logic rd, input logic m2r,
                              input logic rw, input logic sa, input logic [1:0] sb,
                              input logic [2:0] ac, input logic [1:0] ps, input logic il);
    return {pe, io, mw, irw, rd, m2r, rw, sa, sb, ac, ps, il};
  endfunction

  // Expected vector while reset is low: pcen, memwrite, irwrite, regwrite, illegal cleared
  function automatic vec_t gated(input vec_t v);
    vec_t g;
    g = v;
    g[18]    = 1'b0;
    g[16]    = 1'b0;
    g[15:12] = 4'b0000;
    g[9]     = 1'b0;
    g[0]     = 1'b0;
    return g;
  endfunction

  function automatic vec_t fetch(input int n);
    logic [3:0] lane;
    lane = 4'b0001 << (n - 1);
    return mk(1, 0, 0, lane, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
  endfunction

  function automatic vec_t decode(input logic il);
    return mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, il);
  endfunction

  task automatic push_fetch_decode(input logic il);
    for (int n = 1; n <= 4; n++) sb_q.push_back(fetch(n));
    sb_q.push_back(decode(il));
  endtask

  // Apply n cycles with the given reset level, popping and comparing one vector each
  task automatic run(input int n, input logic rst, input string tag);
    vec_t exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = rst;
      #1;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $error("FAIL %s[%0d] scoreboard empty observed=%b", tag, i, obs);
      end else begin
        exp = sb_q.pop_front();
        assert (obs === exp) else begin
          miscompares++;
          $error("FAIL %s[%0d] observed=%b expected=%b", tag, i, obs, exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    op    = 6'b000000;
    funct = 6'b100000;
    zero  = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: FETCH1 with strobes held low
    sb_q.push_back(gated(fetch(1)));
    sb_q.push_back(gated(fetch(1)));
    run(2, 1'b0, "reset");

    // Reset asserted for 2 cycles in FETCH3 returns to FETCH1
    sb_q.push_back(fetch(1));
    sb_q.push_back(fetch(2));
    run(2, 1'b1, "pre_rst");
    sb_q.push_back(gated(fetch(3)));
    sb_q.push_back(gated(fetch(1)));
    run(2, 1'b0, "mid_rst");

    // lb: 8 cycles
    op = 6'b100000; funct = 6'b000000;
    push_fetch_decode(0);
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
    sb_q.push_back(mk(0, 1, 0, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    run(8, 1'b1, "lb");

    // R-type sub, slt, and: 7 cycles each
    op = 6'b000000; funct = 6'b100010;
    push_fetch_decode(0);
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b00, 3'b110, 2'b00, 0));
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    run(7, 1'b1, "r_sub");

    funct = 6'b101010;
    push_fetch_decode(0);
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b00, 3'b111, 2'b00, 0));
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    run(7, 1'b1, "r_slt");

    funct = 6'b100100;
    push_fetch_decode(0);
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 0));
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    run(7, 1'b1, "r_and");

    // beq taken and not taken: 6 cycles each
    op = 6'b000100; funct = 6'b000000; zero = 1'b1;
    push_fetch_decode(0);
    sb_q.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0));
    run(6, 1'b1, "beq_t");

    zero = 1'b0;
    push_fetch_decode(0);
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0));
    run(6, 1'b1, "beq_nt");

    // j: 6 cycles
    op = 6'b000010;
    push_fetch_decode(0);
    sb_q.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0));
    run(6, 1'b1, "j");

    // sb: 7 cycles
    op = 6'b101000;
    push_fetch_decode(0);
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
    sb_q.push_back(mk(0, 1, 1, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    run(7, 1'b1, "sb");

    // addi: 7 cycles
    op = 6'b001000;
    push_fetch_decode(0);
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
    sb_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    run(7, 1'b1, "addi");

    // Unsupported op, then R-type with unsupported funct: illegal in DECODE only
    op = 6'b111111;
    push_fetch_decode(1);
    run(5, 1'b1, "ill_op");

    op = 6'b000000; funct = 6'b000000;
    push_fetch_decode(1);
    run(5, 1'b1, "ill_fn");

    // Back in FETCH1 after the illegal instruction
    sb_q.push_back(fetch(1));
    run(1, 1'b1, "final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
